// File: rtl/usb_rx_destuff_pkg.sv
// Shared definitions for the full-speed USB receive front end:
// line-state codes, receiver FSM states, default parameters and a width helper.
package usb_rx_destuff_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP  = 3'd3,
        ST_ERR  = 3'd4
    } rx_state_e;

    localparam int SYNC_MIN_ZEROS_DEF = 5;
    localparam int STUFF_LEN_DEF      = 6;

    // Bits needed to hold the value itself (not value-1), minimum 1.
    function automatic int clogb2(input int value);
        int w;
        w = 1;
        while ((1 << w) <= value) w++;
        return w;
    endfunction

endpackage

// File: rtl/usb_rx_destuff_nrzi_dec.sv
// Line-state classifier and NRZI decoder; holds the last J/K seen on the bus.
// Decoded bit and strobe are combinational on the current sample.
module usb_rx_destuff_nrzi_dec
    import usb_rx_destuff_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        sample_i,
    input  logic        dp_i,
    input  logic        dm_i,
    output line_state_e line_o,
    output logic        bit_o,
    output logic        stb_o
);

    line_state_e prev_q, prev_d;

    assign line_o = line_state_e'({dp_i, dm_i});
    assign bit_o  = (line_o == prev_q);
    assign stb_o  = sample_i;

    always_comb begin
        prev_d = prev_q;
        if (sample_i && (line_o == LS_J || line_o == LS_K))
            prev_d = line_o;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            prev_q <= LS_J;
        else
            prev_q <= prev_d;
    end

endmodule

// File: rtl/usb_rx_destuff.sv
// Full-speed USB receiver: SYNC detect, bit-unstuffing, LSB-first byte assembly, EOP detect.
// Optional macro USB_RX_STUFF_CHECK_EN turns a missing stuffed 0 into a receive error.
//
//  state | meaning
//  IDLE  | bus idle, waiting for the first K of SYNC
//  SYNC  | counting SYNC zeros, waiting for the closing 1
//  DATA  | unstuffing and assembling bytes
//  EOP   | SE0 seen, waiting for J
//  ERR   | error; leave only on SE0 followed by J
module usb_rx_destuff
    import usb_rx_destuff_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
    parameter int STUFF_LEN      = STUFF_LEN_DEF
) (
    input  logic       iCLOCK,
    input  logic       iRESET_n,
    input  logic       iSAMPLE,
    input  logic       iDP,
    input  logic       iDM,
    output logic [7:0] oDATA,
    output logic       oDATA_VALID,
    output logic       oRX_ACTIVE,
    output logic       oEOP,
    output logic       oERROR
);

    localparam int ZW = clogb2(SYNC_MIN_ZEROS);
    localparam int OW = clogb2(STUFF_LEN);
    localparam logic [ZW-1:0] ZERO_MIN = ZW'(SYNC_MIN_ZEROS);
    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

    line_state_e line;
    logic        dec_bit;
    logic        dec_stb;

    rx_state_e       state_q, state_d;
    logic [ZW-1:0]   zero_q, zero_d;
    logic [OW-1:0]   ones_q, ones_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [6:0]      shreg_q, shreg_d;
    logic            se0_seen_q, se0_seen_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            active_q, active_d;
    logic            eop_q, eop_d;
    logic            err_q, err_d;

    usb_rx_destuff_nrzi_dec u_nrzi (
        .clk_i    (iCLOCK),
        .rst_n_i  (iRESET_n),
        .sample_i (iSAMPLE),
        .dp_i     (iDP),
        .dm_i     (iDM),
        .line_o   (line),
        .bit_o    (dec_bit),
        .stb_o    (dec_stb)
    );

    always_comb begin
        state_d    = state_q;
        zero_d     = zero_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        se0_seen_d = se0_seen_q;
        data_d     = data_q;
        active_d   = active_q;
        valid_d    = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        if (dec_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (line == LS_K) begin
                        state_d = ST_SYNC;
                        zero_d  = ZW'(1);
                    end
                end
                ST_SYNC: begin
                    case (line)
                        LS_SE0: state_d = ST_IDLE;
                        LS_SE1: begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end
                        default: begin
                            if (!dec_bit) begin
                                if (zero_q != ZERO_MIN) zero_d = zero_q + ZW'(1);
                            end else if (zero_q >= ZERO_MIN) begin
                                state_d   = ST_DATA;
                                active_d  = 1'b1;
                                ones_d    = OW'(1);
                                bit_cnt_d = 3'd0;
                            end else begin
                                state_d = ST_ERR;
                                err_d   = 1'b1;
                            end
                        end
                    endcase
                end
                ST_DATA: begin
                    case (line)
                        LS_SE0: state_d = ST_EOP;
                        LS_SE1: begin
                            state_d  = ST_ERR;
                            active_d = 1'b0;
                            err_d    = 1'b1;
                        end
                        default: begin
                            if (ones_q == ONES_MAX && !dec_bit) begin
                                ones_d = '0;
`ifdef USB_RX_STUFF_CHECK_EN
                            end else if (ones_q == ONES_MAX) begin
                                state_d  = ST_ERR;
                                active_d = 1'b0;
                                err_d    = 1'b1;
`endif
                            end else begin
                                shreg_d   = {dec_bit, shreg_q[6:1]};
                                bit_cnt_d = bit_cnt_q + 3'd1;
                                // Without the stuff check the counter parks at the limit.
                                if (!dec_bit)
                                    ones_d = '0;
                                else if (ones_q != ONES_MAX)
                                    ones_d = ones_q + OW'(1);
                                if (bit_cnt_q == 3'd7) begin
                                    data_d  = {dec_bit, shreg_q};
                                    valid_d = 1'b1;
                                end
                            end
                        end
                    endcase
                end
                ST_EOP: begin
                    case (line)
                        LS_SE0: state_d = ST_EOP;
                        LS_J: begin
                            state_d  = ST_IDLE;
                            active_d = 1'b0;
                            if (bit_cnt_q == 3'd0) eop_d = 1'b1;
                            else                   err_d = 1'b1;
                        end
                        default: begin
                            state_d  = ST_ERR;
                            active_d = 1'b0;
                            err_d    = 1'b1;
                        end
                    endcase
                end
                ST_ERR: begin
                    active_d = 1'b0;
                    if (line == LS_SE0) begin
                        se0_seen_d = 1'b1;
                    end else if (line == LS_J && se0_seen_q) begin
                        state_d    = ST_IDLE;
                        se0_seen_d = 1'b0;
                    end else begin
                        se0_seen_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            state_q    <= ST_IDLE;
            zero_q     <= '0;
            ones_q     <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            se0_seen_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            zero_q     <= zero_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            se0_seen_q <= se0_seen_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
        end
    end

    assign oDATA       = data_q;
    assign oDATA_VALID = valid_q;
    assign oRX_ACTIVE  = active_q;
    assign oEOP        = eop_q;
    assign oERROR      = err_q;

endmodule

// File: tb/tb_usb_rx_destuff.sv
// Bench for usb_rx_destuff: a transmit-side encoder (SYNC, bit stuffing, NRZI) produces
// the line, and received bytes/strobes are compared with what was sent.
module tb_usb_rx_destuff;

    logic       iCLOCK = 1'b0;
    logic       iRESET_n = 1'b0;
    logic       iSAMPLE = 1'b0;
    logic       iDP = 1'b1;
    logic       iDM = 1'b0;
    logic [7:0] oDATA;
    logic       oDATA_VALID, oRX_ACTIVE, oEOP, oERROR;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    logic [1:0] tx_lvl = J;
    int         gap = 1;
    logic [7:0] pkt[$];
    bit         tx_bits[$];
    logic [7:0] got_q[$];
    int         eop_cnt = 0;
    int         err_cnt = 0;
    bit         overlap = 1'b0;

    always #5 iCLOCK = ~iCLOCK;

    usb_rx_destuff dut (
        .iCLOCK      (iCLOCK),
        .iRESET_n    (iRESET_n),
        .iSAMPLE     (iSAMPLE),
        .iDP         (iDP),
        .iDM         (iDM),
        .oDATA       (oDATA),
        .oDATA_VALID (oDATA_VALID),
        .oRX_ACTIVE  (oRX_ACTIVE),
        .oEOP        (oEOP),
        .oERROR      (oERROR)
    );

    always @(negedge iCLOCK) begin
        if (oDATA_VALID) got_q.push_back(oDATA);
        if (oEOP) eop_cnt++;
        if (oERROR) err_cnt++;
        if (oEOP && oERROR) overlap = 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        eop_cnt = 0;
        err_cnt = 0;
        overlap = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where the sample's result is visible.
    task automatic send_sym(input logic [1:0] ls);
        repeat (gap) @(negedge iCLOCK);
        {iDP, iDM} = ls;
        iSAMPLE = 1'b1;
        @(negedge iCLOCK);
        iSAMPLE = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        if (!b) tx_lvl = (tx_lvl == J) ? K : J;
        send_sym(tx_lvl);
    endtask

    task automatic send_eop();
        send_sym(SE0);
        send_sym(SE0);
        send_sym(J);
        tx_lvl = J;
    endtask

    // SYNC (nz zeros then 1) followed by pkt LSB-first; a 0 follows every six 1s when stuffing.
    task automatic build_bits(input int nz, input bit stuff);
        int         ones;
        logic [7:0] cur;
        tx_bits.delete();
        repeat (nz) tx_bits.push_back(1'b0);
        tx_bits.push_back(1'b1);
        ones = 1;
        foreach (pkt[i]) begin
            cur = pkt[i];
            for (int j = 0; j < 8; j++) begin
                tx_bits.push_back(cur[j]);
                if (cur[j]) ones++;
                else ones = 0;
                if (stuff && ones == 6) begin
                    tx_bits.push_back(1'b0);
                    ones = 0;
                end
            end
        end
    endtask

    task automatic send_packet(input int nz, input bit stuff);
        build_bits(nz, stuff);
        foreach (tx_bits[i]) send_bit(tx_bits[i]);
        send_eop();
    endtask

    task automatic check_result(input string name, input int exp_n, input int exp_eop, input int exp_err);
        repeat (3) @(negedge iCLOCK);
        check({name, "_nbytes"}, got_q.size(), exp_n);
        for (int i = 0; i < exp_n && i < got_q.size(); i++)
            check({name, "_byte"}, got_q[i], pkt[i]);
        if (exp_n > 0) check({name, "_odata"}, oDATA, pkt[exp_n-1]);
        check({name, "_eop_cnt"}, eop_cnt, exp_eop);
        check({name, "_err_cnt"}, err_cnt, exp_err);
        check({name, "_rx_active_low"}, oRX_ACTIVE, 0);
        check({name, "_eop_err_apart"}, overlap, 0);
        clear_mon();
    endtask

    typedef struct {
        int         nz;
        int         nb;
        logic [7:0] b0, b1, b2;
        int         exp_n;
        int         exp_eop;
        int         exp_err;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{7, 1, 8'hA5, 8'h00, 8'h00, 1, 1, 0};
        vt[1] = '{7, 2, 8'h3F, 8'h00, 8'h00, 2, 1, 0};
        vt[2] = '{4, 1, 8'hA5, 8'h00, 8'h00, 0, 0, 1};
        vt[3] = '{5, 1, 8'hA5, 8'h00, 8'h00, 1, 1, 0};
        vt[4] = '{6, 2, 8'hFF, 8'h01, 8'h00, 2, 1, 0};
        vt[5] = '{7, 3, 8'h7E, 8'h81, 8'hC3, 3, 1, 0};
        vt[6] = '{3, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1};
        vt[7] = '{8, 1, 8'hFE, 8'h00, 8'h00, 1, 1, 0};

        // Reset state
        repeat (3) @(negedge iCLOCK);
        check("rst_odata", oDATA, 0);
        check("rst_valid", oDATA_VALID, 0);
        check("rst_active", oRX_ACTIVE, 0);
        check("rst_eop", oEOP, 0);
        check("rst_err", oERROR, 0);
        iRESET_n = 1'b1;
        {iDP, iDM} = J;
        repeat (2) send_sym(J);
        clear_mon();

        for (int v = 0; v < 8; v++) begin
            pkt.delete();
            pkt.push_back(vt[v].b0);
            if (vt[v].nb > 1) pkt.push_back(vt[v].b1);
            if (vt[v].nb > 2) pkt.push_back(vt[v].b2);
            send_packet(vt[v].nz, 1'b1);
            check_result($sformatf("vec%0d", v), vt[v].exp_n, vt[v].exp_eop, vt[v].exp_err);
        end

        // Strobe timing around EOP
        pkt = '{8'hA5};
        build_bits(7, 1'b1);
        foreach (tx_bits[i]) send_bit(tx_bits[i]);
        send_sym(SE0);
        send_sym(SE0);
        check("eop_active_during_se0", oRX_ACTIVE, 1);
        send_sym(J);
        tx_lvl = J;
        check("eop_strobe", oEOP, 1);
        check("eop_active_fall", oRX_ACTIVE, 0);
        check("eop_no_err", oERROR, 0);
        @(negedge iCLOCK);
        check("eop_one_cycle", oEOP, 0);
        check_result("eop_seq", 1, 1, 0);

        // SE0 after 3 data bits: partial byte
        pkt = '{8'hA5};
        build_bits(7, 1'b1);
        for (int i = 0; i < 11; i++) send_bit(tx_bits[i]);
        send_eop();
        pkt.delete();
        check_result("partial_byte", 0, 0, 1);

        // SE1 mid-byte
        pkt = '{8'h5A};
        build_bits(7, 1'b1);
        for (int i = 0; i < 12; i++) send_bit(tx_bits[i]);
        check("se1_active_before", oRX_ACTIVE, 1);
        send_sym(SE1);
        check("se1_err_strobe", oERROR, 1);
        check("se1_active_drop", oRX_ACTIVE, 0);
        send_sym(SE0);
        send_sym(J);
        tx_lvl = J;
        check_result("se1_seq", 0, 0, 1);
        pkt = '{8'h5A};
        send_packet(7, 1'b1);
        check_result("se1_recover", 1, 1, 0);

        // Eight 1s in a row with no stuffed 0
        pkt = '{8'hFF};
        build_bits(7, 1'b0);
        foreach (tx_bits[i]) send_bit(tx_bits[i]);
        send_eop();
`ifdef USB_RX_STUFF_CHECK_EN
        check_result("missing_stuff_err", 0, 0, 1);
`else
        check_result("missing_stuff_ok", 1, 1, 0);
`endif
        pkt = '{8'h3C};
        send_packet(7, 1'b1);
        check_result("after_missing_stuff", 1, 1, 0);

        // Asynchronous reset mid-byte
        pkt = '{8'hC3, 8'h96};
        build_bits(7, 1'b1);
        for (int i = 0; i < 20; i++) send_bit(tx_bits[i]);
        check("arst_active_before", oRX_ACTIVE, 1);
        check("arst_odata_before", oDATA, 8'hC3);
        #2 iRESET_n = 1'b0;
        #1;
        check("arst_odata", oDATA, 0);
        check("arst_active", oRX_ACTIVE, 0);
        check("arst_valid", oDATA_VALID, 0);
        check("arst_eop", oEOP, 0);
        check("arst_err", oERROR, 0);
        @(negedge iCLOCK);
        @(negedge iCLOCK);
        iRESET_n = 1'b1;
        tx_lvl = J;
        {iDP, iDM} = J;
        clear_mon();
        repeat (2) send_sym(J);
        pkt = '{8'h96};
        send_packet(7, 1'b1);
        check_result("arst_next_pkt", 1, 1, 0);

        // Line activity with iSAMPLE low must be ignored
        pkt = '{8'h5A};
        build_bits(7, 1'b1);
        for (int i = 0; i < 11; i++) send_bit(tx_bits[i]);
        for (int c = 0; c < 12; c++) begin
            @(negedge iCLOCK);
            {iDP, iDM} = 2'($urandom_range(0, 3));
        end
        check("nosample_active_hold", oRX_ACTIVE, 1);
        check("nosample_no_err", err_cnt, 0);
        for (int i = 11; i < tx_bits.size(); i++) send_bit(tx_bits[i]);
        send_eop();
        check_result("nosample_pkt", 1, 1, 0);

        // Random packets with random sample spacing
        for (int p = 0; p < 25; p++) begin
            int nb;
            int nz;
            nb  = $urandom_range(1, 4);
            nz  = $urandom_range(5, 8);
            gap = $urandom_range(0, 3);
            pkt.delete();
            for (int k = 0; k < nb; k++) pkt.push_back(8'($urandom()));
            repeat ($urandom_range(0, 3)) send_sym(J);
            clear_mon();
            send_packet(nz, 1'b1);
            check_result($sformatf("rnd%0d", p), nb, 1, 0);
        end
        gap = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
